// File: rtl/rotate_shift_unit.sv
// rtl/rotate_shift_unit.sv - multi-mode rotate/shift unit with valid/ready handshake
// Define ROTSHIFT_BARREL_EN for single-cycle barrel evaluation instead of one bit per clock.
module rotate_shift_unit #(
   parameter int WIDTH = 5,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [2:0]       op,
   input  logic [SHW-1:0]   shift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             cf,
   output logic             sf,
   output logic             zf
);
   localparam int CW = $clog2(WIDTH + 1);

`ifdef ROTSHIFT_BARREL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic             cf_q, cf_d;
   logic [CW-1:0]    eff;
`ifndef ROTSHIFT_BARREL_EN
   logic [CW-1:0]    count_q, count_d;
   logic [2:0]       op_q, op_d;
`endif

   // One bit-position step; result is {carry_out, new_value}.
   function automatic logic [WIDTH:0] step_f(input logic [WIDTH-1:0] v, input logic [2:0] o);
      case (o)
         3'b000:  step_f = {v[0], v[0], v[WIDTH-1:1]};
         3'b001:  step_f = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         3'b010:  step_f = {v[0], 1'b0, v[WIDTH-1:1]};
         3'b011:  step_f = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         3'b100:  step_f = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         default: step_f = {1'b0, v};
      endcase
   endfunction

   always_comb begin : eff_calc
      logic [31:0] sh;
      sh  = 32'(shift);
      eff = '0;
      case (op)
         3'b000, 3'b001:         eff = CW'(sh % WIDTH);
         3'b010, 3'b011, 3'b100: eff = (sh > WIDTH) ? CW'(WIDTH) : CW'(sh);
         default:                eff = '0;
      endcase
   end

`ifdef ROTSHIFT_BARREL_EN
   logic [WIDTH:0] barrel;

   always_comb begin
      barrel = {1'b0, a};
      for (int i = 0; i < WIDTH; i++) begin
         if (i < int'(eff)) barrel = step_f(barrel[WIDTH-1:0], op);
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      z_d       = z_q;
      cf_d      = cf_q;
`ifndef ROTSHIFT_BARREL_EN
      count_d   = count_q;
      op_d      = op_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
`ifdef ROTSHIFT_BARREL_EN
               z_d     = barrel[WIDTH-1:0];
               cf_d    = barrel[WIDTH];
               state_d = DONE;
`else
               z_d     = a;
               cf_d    = 1'b0;
               count_d = eff;
               op_d    = op;
               state_d = (eff != '0) ? SHIFT : DONE;
`endif
            end
         end
`ifndef ROTSHIFT_BARREL_EN
         SHIFT: begin
            {cf_d, z_d} = step_f(z_q, op_q);
            count_d     = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = DONE;
         end
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         z_q     <= '0;
         cf_q    <= 1'b0;
`ifndef ROTSHIFT_BARREL_EN
         count_q <= '0;
         op_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         cf_q    <= cf_d;
`ifndef ROTSHIFT_BARREL_EN
         count_q <= count_d;
         op_q    <= op_d;
`endif
      end
   end

   assign z  = z_q;
   assign cf = cf_q;
   assign sf = z_q[WIDTH-1];
   assign zf = (z_q == '0);

endmodule

// File: tb/tb_rotate_shift_unit.sv
// tb/tb_rotate_shift_unit.sv - randomized self-checking bench for rotate_shift_unit
module tb_rotate_shift_unit;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [2:0]   op = '0;
   logic [2:0]   shift = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] z;
   logic         cf, sf, zf;

   int n_checks = 0;
   int n_fail   = 0;

   rotate_shift_unit #(.WIDTH(W), .SHW(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .op(op), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
      .z(z), .cf(cf), .sf(sf), .zf(zf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference computed directly from the mathematical definition of each op.
   function automatic void model(input int av, input int o, input int sh,
                                 output int ez, output int ecf, output int e);
      int m;
      m = (1 << W) - 1;
      case (o)
         0, 1:    e = sh % W;
         2, 3, 4: e = (sh > W) ? W : sh;
         default: e = 0;
      endcase
      ez  = av;
      ecf = 0;
      if (e > 0) begin
         case (o)
            0: begin ez = ((av >> e) | (av << (W - e))) & m; ecf = (av >> (e - 1)) & 1; end
            1: begin ez = ((av << e) | (av >> (W - e))) & m; ecf = (av >> (W - e)) & 1; end
            2: begin ez = av >> e;                            ecf = (av >> (e - 1)) & 1; end
            3: begin ez = (av << e) & m;                      ecf = (av >> (W - e)) & 1; end
            4: begin
               ez  = (av >> e) | ((((av >> (W - 1)) & 1) != 0) ? (m & ~(m >> e)) : 0);
               ecf = (av >> (e - 1)) & 1;
            end
            default: ;
         endcase
      end
   endfunction

   task automatic run_op(input int av, input int o, input int sh, input int hold);
      int ez, ecf, e, lat, exp_lat;
      logic [W-1:0] z_hold;
      logic         cf_hold;
      model(av, o, sh, ez, ecf, e);
`ifdef ROTSHIFT_BARREL_EN
      exp_lat = 0;
`else
      exp_lat = e;
`endif
      a = W'(av); op = 3'(o); shift = 3'(sh); in_valid = 1'b1;
      check("in_ready_idle", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); op = 3'($urandom); shift = 3'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("z", int'(z), ez);
      check("cf", int'(cf), ecf);
      check("sf", int'(sf), (ez >> (W - 1)) & 1);
      check("zf", int'(zf), (ez == 0) ? 1 : 0);
      z_hold = z; cf_hold = cf;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = W'($urandom); op = 3'($urandom); shift = 3'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_z", int'(z), ez);
         check("bp_cf", int'(cf), ecf);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release_out_valid", int'(out_valid), 0);
      check("release_in_ready", int'(in_ready), 1);
      check("release_z_held", int'(z), int'(z_hold));
      check("release_cf_held", int'(cf), int'(cf_hold));
   endtask

   initial begin
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_z", int'(z), 0);
      check("rst_cf", int'(cf), 0);
      check("rst_sf", int'(sf), 0);
      check("rst_zf", int'(zf), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(5'b10011, 0, 1, 0);
      run_op(5'b10011, 0, 5, 0);
      run_op(5'b10011, 0, 6, 0);
      run_op(5'b10011, 3, 7, 0);
      run_op(5'b10011, 4, 2, 0);
      run_op(5'b10011, 2, 2, 0);
      run_op(5'b10110, 1, 3, 4);
      run_op(5'b01101, 6, 3, 1);

      // Asynchronous reset in the middle of a ROL by 4.
      a = 5'b10110; op = 3'd1; shift = 3'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_z", int'(z), 0);
      check("midrst_cf", int'(cf), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(5'b11010, 1, 4, 0);

      for (int k = 0; k < 60; k++) begin
         run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
